// File: rtl/bsg_wormhole_router_packet_splitter.sv
// Splits a wormhole packet stream into a held header register and a streamed body interface.
// The length field in the header counts the body flits that follow it.
module bsg_wormhole_router_packet_splitter #(
  parameter int flit_width_p = 32,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [flit_width_p-1:0] fifo_data_i,
  input  logic                    fifo_v_i,
  output logic                    fifo_yumi_o,
  output logic [flit_width_p-1:0] hdr_o,
  output logic                    hdr_v_o,
  input  logic                    hdr_yumi_i,
  output logic [flit_width_p-1:0] data_o,
  output logic                    data_v_o,
  output logic                    data_last_o,
  input  logic                    data_yumi_i
);

  typedef enum logic {S_HDR, S_BODY} state_e;

  state_e                  state_r, state_n;
  logic                    hdr_full_r;
  logic [len_width_p-1:0]  remaining_r;
  logic [flit_width_p-1:0] hdr_r;
  logic [len_width_p-1:0]  len;
  logic                    hdr_capture;
  logic                    body_take;
  logic                    on_last;

  assign len     = fifo_data_i[len_offset_p +: len_width_p];
  assign on_last = (remaining_r == len_width_p'(1));

  always_comb begin
    state_n     = state_r;
    fifo_yumi_o = 1'b0;
    data_v_o    = 1'b0;
    hdr_capture = 1'b0;
    body_take   = 1'b0;
    case (state_r)
      S_HDR: begin
        // Gated by reset so the upstream FIFO never loses a flit while we are held.
        hdr_capture = fifo_v_i & (~hdr_full_r | hdr_yumi_i) & ~reset_i;
        fifo_yumi_o = hdr_capture;
        if (hdr_capture && (len != '0)) state_n = S_BODY;
      end
      S_BODY: begin
        data_v_o    = fifo_v_i;
        body_take   = data_yumi_i;
        fifo_yumi_o = data_yumi_i;
        if (data_yumi_i && on_last) state_n = S_HDR;
      end
      default: state_n = S_HDR;
    endcase
  end

  assign data_last_o = data_v_o & on_last;
  assign data_o      = fifo_data_i;
  assign hdr_o       = hdr_r;
  assign hdr_v_o     = hdr_full_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= S_HDR;
      hdr_full_r  <= 1'b0;
      remaining_r <= '0;
    end else begin
      state_r <= state_n;
      if (hdr_capture)     hdr_full_r <= 1'b1;
      else if (hdr_yumi_i) hdr_full_r <= 1'b0;
      if (hdr_capture)     remaining_r <= len;
      else if (body_take)  remaining_r <= remaining_r - len_width_p'(1);
    end
  end

  // Header payload needs no reset; hdr_full_r qualifies it.
  always_ff @(posedge clk_i) begin
    if (hdr_capture) hdr_r <= fifo_data_i;
  end

  a_hdr_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
    !(hdr_yumi_i && !hdr_v_o)) else $error("hdr_yumi_i asserted without hdr_v_o");
  a_data_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
    !(data_yumi_i && !data_v_o)) else $error("data_yumi_i asserted without data_v_o");

endmodule

// File: tb/tb_bsg_wormhole_router_packet_splitter.sv
// Self-checking bench: directed scenarios plus random traffic against a packet-level scoreboard.
module tb_bsg_wormhole_router_packet_splitter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fifo_data;
  logic        fifo_v, fifo_yumi;
  logic [31:0] hdr;
  logic        hdr_v, hdr_yumi;
  logic [31:0] data;
  logic        data_v, data_last, data_yumi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bsg_wormhole_router_packet_splitter #(.flit_width_p(32), .len_width_p(4), .len_offset_p(0)) dut (
    .clk_i(clk), .reset_i(rst),
    .fifo_data_i(fifo_data), .fifo_v_i(fifo_v), .fifo_yumi_o(fifo_yumi),
    .hdr_o(hdr), .hdr_v_o(hdr_v), .hdr_yumi_i(hdr_yumi),
    .data_o(data), .data_v_o(data_v), .data_last_o(data_last), .data_yumi_i(data_yumi)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic fv, input logic [31:0] fd, input logic hy, input logic dy);
    fifo_v = fv; fifo_data = fd; hdr_yumi = hy; data_yumi = dy; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step(); step();
    checks++; if (hdr_v !== 1'b0) begin errors++; $display("FAIL reset_hdr_v got=%b exp=0", hdr_v); end
    checks++; if (data_v !== 1'b0) begin errors++; $display("FAIL reset_data_v got=%b exp=0", data_v); end
    checks++; if (data_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", data_last); end
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    checks++; if (data !== 32'h5) begin errors++; $display("FAIL reset_data_follow got=%h exp=00000005", data); end
    checks++; if (fifo_yumi !== 1'b0) begin errors++; $display("FAIL reset_fifo_yumi got=%b exp=0", fifo_yumi); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    checks++; if (hdr_v !== 1'b0) begin errors++; $display("FAIL reset_no_capture got=%b exp=0", hdr_v); end
  endtask

  task automatic test_basic();
    logic [31:0] body [3];
    body[0] = 32'hA; body[1] = 32'hB; body[2] = 32'hC;
    drive(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    checks++; if (fifo_yumi !== 1'b1) begin errors++; $display("FAIL basic_hdr_yumi got=%b exp=1", fifo_yumi); end
    checks++; if (hdr_v !== 1'b0) begin errors++; $display("FAIL basic_hdr_v_early got=%b exp=0", hdr_v); end
    step();
    checks++; if (hdr_v !== 1'b1 || hdr !== 32'h3) begin errors++; $display("FAIL basic_hdr got=%b/%h exp=1/00000003", hdr_v, hdr); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, body[i], 1'b0, 1'b1);
      checks++;
      if (data_v !== 1'b1 || data !== body[i] || data_last !== (i == 2) || fifo_yumi !== 1'b1) begin
        errors++; $display("FAIL basic_body%0d got v=%b d=%h last=%b y=%b exp v=1 d=%h last=%b y=1",
                           i, data_v, data, data_last, fifo_yumi, body[i], (i == 2));
      end
      step();
    end
    // Back in header state: header reg still full and not yumi'd, so nothing moves.
    drive(1'b1, 32'h0000_0010, 1'b0, 1'b0);
    checks++; if (data_v !== 1'b0 || fifo_yumi !== 1'b0) begin errors++; $display("FAIL basic_after got v=%b y=%b exp 0/0", data_v, fifo_yumi); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checks++; if (hdr_v !== 1'b0) begin errors++; $display("FAIL basic_hdr_clear got=%b exp=0", hdr_v); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h0000_0010, 1'b0, 1'b0);
    checks++; if (fifo_yumi !== 1'b1) begin errors++; $display("FAIL b2b_first_yumi got=%b exp=1", fifo_yumi); end
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0000_0020, 1'b0, 1'b0);
      checks++; if (fifo_yumi !== 1'b0) begin errors++; $display("FAIL b2b_hold%0d got=%b exp=0", i, fifo_yumi); end
      step();
      checks++; if (hdr_v !== 1'b1 || hdr !== 32'h10) begin errors++; $display("FAIL b2b_held%0d got=%b/%h exp=1/00000010", i, hdr_v, hdr); end
    end
    drive(1'b1, 32'h0000_0020, 1'b1, 1'b0);
    checks++; if (fifo_yumi !== 1'b1) begin errors++; $display("FAIL b2b_second_yumi got=%b exp=1", fifo_yumi); end
    step();
    checks++; if (hdr_v !== 1'b1 || hdr !== 32'h20) begin errors++; $display("FAIL b2b_switch got=%b/%h exp=1/00000020", hdr_v, hdr); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checks++; if (hdr_v !== 1'b0) begin errors++; $display("FAIL b2b_clear got=%b exp=0", hdr_v); end
  endtask

  task automatic test_bubbles();
    drive(1'b1, 32'h0000_0002, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (data_v !== 1'b0) begin errors++; $display("FAIL bub_gap0 got=%b exp=0", data_v); end
    step();
    drive(1'b1, 32'hB1, 1'b0, 1'b0);
    checks++; if (data_v !== 1'b1 || data_last !== 1'b0 || fifo_yumi !== 1'b0) begin errors++; $display("FAIL bub_stall1 got v=%b last=%b y=%b exp 1/0/0", data_v, data_last, fifo_yumi); end
    step();
    drive(1'b1, 32'hB1, 1'b0, 1'b1);
    checks++; if (data !== 32'hB1 || data_last !== 1'b0 || fifo_yumi !== 1'b1) begin errors++; $display("FAIL bub_take1 got d=%h last=%b y=%b exp 000000b1/0/1", data, data_last, fifo_yumi); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (data_v !== 1'b0 || data_last !== 1'b0) begin errors++; $display("FAIL bub_gap1 got v=%b last=%b exp 0/0", data_v, data_last); end
    step();
    drive(1'b1, 32'hB2, 1'b0, 1'b0);
    checks++; if (data_v !== 1'b1 || data_last !== 1'b1) begin errors++; $display("FAIL bub_stall2 got v=%b last=%b exp 1/1", data_v, data_last); end
    step();
    drive(1'b1, 32'hB2, 1'b0, 1'b1);
    checks++; if (data_last !== 1'b1 || fifo_yumi !== 1'b1) begin errors++; $display("FAIL bub_take2 got last=%b y=%b exp 1/1", data_last, fifo_yumi); end
    step();
    checks++; if (hdr_v !== 1'b1 || hdr !== 32'h2) begin errors++; $display("FAIL bub_hdr_kept got=%b/%h exp=1/00000002", hdr_v, hdr); end
    drive(1'b1, 32'h0000_0030, 1'b1, 1'b0);
    checks++; if (data_v !== 1'b0 || fifo_yumi !== 1'b1) begin errors++; $display("FAIL bub_next_hdr got v=%b y=%b exp 0/1", data_v, fifo_yumi); end
    step();
    checks++; if (hdr !== 32'h30) begin errors++; $display("FAIL bub_hdr2 got=%h exp=00000030", hdr); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_max_len();
    int lasts;
    lasts = 0;
    drive(1'b1, 32'h0000_AB0F, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 15; i++) begin
      drive(1'b1, 32'hB000_0000 + i, 1'b0, 1'b1);
      if (data_last === 1'b1) lasts++;
      checks++;
      if (data_v !== 1'b1 || data !== 32'hB000_0000 + i || data_last !== (i == 15)) begin
        errors++; $display("FAIL max_body%0d got v=%b d=%h last=%b exp last=%b", i, data_v, data, data_last, (i == 15));
      end
      step();
    end
    checks++; if (lasts != 1) begin errors++; $display("FAIL max_last_count got=%0d exp=1", lasts); end
    drive(1'b1, 32'hC000_0000, 1'b1, 1'b0);
    checks++; if (data_v !== 1'b0 || fifo_yumi !== 1'b1) begin errors++; $display("FAIL max_16th got v=%b y=%b exp 0/1", data_v, fifo_yumi); end
    step();
    checks++; if (hdr_v !== 1'b1 || hdr !== 32'hC000_0000) begin errors++; $display("FAIL max_16th_hdr got=%b/%h exp=1/c0000000", hdr_v, hdr); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hD1, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'hD2, 1'b0, 1'b0);
    checks++; if (data_v !== 1'b1 || hdr_v !== 1'b1) begin errors++; $display("FAIL ar_pre got v=%b hv=%b exp 1/1", data_v, hdr_v); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (data_v !== 1'b0 || hdr_v !== 1'b0 || data_last !== 1'b0 || fifo_yumi !== 1'b0) begin
      errors++; $display("FAIL ar_drop got v=%b hv=%b last=%b y=%b exp 0/0/0/0", data_v, hdr_v, data_last, fifo_yumi);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
    drive(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    checks++; if (fifo_yumi !== 1'b1 || data_v !== 1'b0) begin errors++; $display("FAIL ar_hdr_take got y=%b v=%b exp 1/0", fifo_yumi, data_v); end
    step();
    checks++; if (hdr_v !== 1'b1 || hdr !== 32'h1) begin errors++; $display("FAIL ar_hdr got=%b/%h exp=1/00000001", hdr_v, hdr); end
    drive(1'b1, 32'hE1, 1'b0, 1'b1);
    checks++; if (data_v !== 1'b1 || data_last !== 1'b1) begin errors++; $display("FAIL ar_body got v=%b last=%b exp 1/1", data_v, data_last); end
    step();
    drive(1'b1, 32'hE2, 1'b0, 1'b0);
    checks++; if (data_v !== 1'b0) begin errors++; $display("FAIL ar_done got=%b exp=0", data_v); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_random();
    logic [31:0] src[$];
    logic [31:0] exp_hdr[$];
    logic [31:0] exp_body[$];
    bit          exp_last[$];
    int          len;
    int          cyc;
    logic [31:0] h, f;
    for (int p = 0; p < 40; p++) begin
      len = (p % 7 == 3) ? 15 : $urandom_range(0, 5);
      h = ($urandom & 32'hFFFF_FFF0) | 32'(len);
      src.push_back(h); exp_hdr.push_back(h);
      for (int b = 1; b <= len; b++) begin
        f = $urandom;
        src.push_back(f); exp_body.push_back(f); exp_last.push_back(b == len);
      end
    end
    cyc = 0;
    while ((src.size() > 0 || exp_hdr.size() > 0 || exp_body.size() > 0) && cyc < 5000) begin
      fifo_v = (src.size() > 0) && ($urandom_range(0, 3) != 0);
      fifo_data = (src.size() > 0) ? src[0] : $urandom;
      hdr_yumi = 1'b0; data_yumi = 1'b0;
      #1;
      hdr_yumi = hdr_v && ($urandom_range(0, 2) != 0);
      data_yumi = data_v && ($urandom_range(0, 3) != 0);
      #1;
      if (hdr_yumi) begin
        checks++;
        if (exp_hdr.size() == 0) begin errors++; $display("FAIL rnd_extra_hdr got=%h", hdr); end
        else begin
          h = exp_hdr.pop_front();
          if (hdr !== h) begin errors++; $display("FAIL rnd_hdr got=%h exp=%h", hdr, h); end
        end
      end
      if (data_yumi) begin
        checks++;
        if (exp_body.size() == 0) begin errors++; $display("FAIL rnd_extra_body got=%h", data); end
        else begin
          f = exp_body.pop_front();
          if (data !== f || data_last !== exp_last[0]) begin
            errors++; $display("FAIL rnd_body got=%h/%b exp=%h/%b", data, data_last, f, exp_last[0]);
          end
          void'(exp_last.pop_front());
        end
      end
      if (fifo_yumi === 1'b1) begin
        checks++;
        if (!fifo_v) begin errors++; $display("FAIL rnd_yumi_no_valid got=1 exp=0"); end
        else void'(src.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (src.size() != 0 || exp_hdr.size() != 0 || exp_body.size() != 0) begin
      errors++; $display("FAIL rnd_timeout left src=%0d hdr=%0d body=%0d exp 0/0/0", src.size(), exp_hdr.size(), exp_body.size());
    end
    checks++; if (hdr_v !== 1'b0) begin errors++; $display("FAIL rnd_end_hdr_v got=%b exp=0", hdr_v); end
  endtask

  initial begin
    fifo_v = 1'b0; fifo_data = '0; hdr_yumi = 1'b0; data_yumi = 1'b0; rst = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_bubbles();
    test_max_len();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
